// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core constants: memory geometry, transfer limits and the
// mem_reader state encoding.
package chip8_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned MAX_LEN    = 16;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_REQ    = 2'd1,
        RD_WAIT   = 2'd2,
        RD_FINISH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/mem_reader.sv
// Multi-byte memory reader: issues one read per byte from a latched base
// address and streams the returned bytes out with their offsets.
module mem_reader #(
    parameter int unsigned ADDR_WIDTH = chip8_pkg::ADDR_WIDTH,
    parameter int unsigned MAX_LEN    = chip8_pkg::MAX_LEN,
    localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1),
    localparam int unsigned IDX_W     = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [7:0]            mem_read_data,
    input  logic                  mem_read_ack,
    output logic                  data_valid,
    output logic [7:0]            data,
    output logic [IDX_W-1:0]      data_index,
    output logic                  done
);

    import chip8_pkg::*;

    rd_state_e             state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      len_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  busy_q;
    logic                  mem_read_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  data_valid_q;
    logic [7:0]            data_q;
    logic [IDX_W-1:0]      data_index_q;
    logic                  done_q;

    logic [CNT_W-1:0]      len_clamped_c;
    logic [IDX_W-1:0]      idx_next_c;
    logic                  last_c;

    // Length clamp, next offset and last-byte detect.
    always_comb begin
        len_clamped_c = (count > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : count;
        idx_next_c    = idx_q + IDX_W'(1);
        last_c        = ((CNT_W'(idx_q) + CNT_W'(1)) == len_q);
    end

    // Transfer FSM; strobes default low and are raised only on the cycle they apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            rd_addr_q    <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            data_index_q <= '0;
            done_q       <= 1'b0;
        end else begin
            mem_read_q   <= 1'b0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            // Empty transfer: done appears in the very next cycle.
                            done_q  <= 1'b1;
                            state_q <= RD_FINISH;
                        end else begin
                            base_q     <= start_addr;
                            len_q      <= len_clamped_c;
                            idx_q      <= '0;
                            busy_q     <= 1'b1;
                            mem_read_q <= 1'b1;
                            rd_addr_q  <= start_addr;
                            state_q    <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_read_ack) begin
                        data_q       <= mem_read_data;
                        data_index_q <= idx_q;
                        data_valid_q <= 1'b1;
                        if (last_c) begin
                            state_q <= RD_FINISH;
                        end else begin
                            // Next request overlaps this byte's data_valid cycle.
                            idx_q      <= idx_next_c;
                            mem_read_q <= 1'b1;
                            rd_addr_q  <= base_q + ADDR_WIDTH'(idx_next_c);
                            state_q    <= RD_REQ;
                        end
                    end
                end
                RD_FINISH: begin
                    // An empty transfer already pulsed done on entry.
                    done_q  <= ~done_q;
                    busy_q  <= 1'b0;
                    state_q <= RD_IDLE;
                end
                default: begin
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign mem_read      = mem_read_q;
    assign mem_read_addr = rd_addr_q;
    assign data_valid    = data_valid_q;
    assign data          = data_q;
    assign data_index    = data_index_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader with a byte memory model and an expected-beat
// scoreboard checked whenever the reader strobes data_valid or mem_read.
module tb_mem_reader;

    localparam int unsigned ML = 16;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] i;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] start_addr;
    logic [4:0]  count;
    logic        busy;
    logic        mem_read;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_read_data;
    logic        mem_read_ack;
    logic        data_valid;
    logic [7:0]  data;
    logic [3:0]  data_index;
    logic        done;

    always #5 clk = ~clk;

    mem_reader #(.ADDR_WIDTH(12), .MAX_LEN(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .count        (count),
        .busy         (busy),
        .mem_read     (mem_read),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_read_ack (mem_read_ack),
        .data_valid   (data_valid),
        .data         (data),
        .data_index   (data_index),
        .done         (done)
    );

    // Memory model: ack ack_delay cycles after the cycle following mem_read.
    logic [7:0]  mem [0:4095];
    logic        ack_q   = 1'b0;
    logic        ack_force;
    logic [7:0]  rdata_q = 8'h00;
    logic        pend_q  = 1'b0;
    int          wait_q  = 0;
    logic [11:0] paddr_q = 12'h000;
    int          ack_delay;

    assign mem_read_ack  = ack_q | ack_force;
    assign mem_read_data = rdata_q;

    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (mem_read) begin
            if (ack_delay == 0) begin
                ack_q   <= 1'b1;
                rdata_q <= mem[mem_read_addr];
            end else begin
                pend_q  <= 1'b1;
                wait_q  <= ack_delay - 1;
                paddr_q <= mem_read_addr;
            end
        end else if (pend_q) begin
            if (wait_q == 0) begin
                ack_q   <= 1'b1;
                rdata_q <= mem[paddr_q];
                pend_q  <= 1'b0;
            end else begin
                wait_q <= wait_q - 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and event timing monitor.
    int          cyc = 0;
    int          start_cyc = 0;
    int          dv_cnt = 0;
    int          done_cnt = 0;
    int          mr_cnt = 0;
    int          done_rel = 0;
    int          mr_first_rel = 0;
    int          dv_rel[$];
    beat_t       exp_q[$];
    logic [11:0] addr_q[$];
    logic [11:0] mon_a;
    beat_t       mon_b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_read) begin
            if (mr_cnt == 0) mr_first_rel = cyc - start_cyc;
            mr_cnt++;
            if (addr_q.size() == 0) begin
                check("mem_read with no pending address", addr_q.size(), 1);
            end else begin
                mon_a = addr_q.pop_front();
                check("mem_read_addr", mem_read_addr, mon_a);
            end
        end
        if (data_valid) begin
            dv_rel.push_back(cyc - start_cyc);
            dv_cnt++;
            if (exp_q.size() == 0) begin
                check("data_valid with empty scoreboard", exp_q.size(), 1);
            end else begin
                mon_b = exp_q.pop_front();
                check("data", data, mon_b.d);
                check("data_index", data_index, mon_b.i);
            end
        end
        if (done) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
            check("busy during done", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm();
        dv_cnt       = 0;
        done_cnt     = 0;
        mr_cnt       = 0;
        done_rel     = 0;
        mr_first_rel = 0;
        dv_rel.delete();
    endtask

    // Push expected beats/addresses, then pulse start for one edge.
    task automatic xfer(input logic [11:0] a, input int n);
        int m;
        logic [11:0] ad;
        m = (n > int'(ML)) ? int'(ML) : n;
        arm();
        for (int i = 0; i < m; i++) begin
            ad = a + 12'(i);
            exp_q.push_back(beat_t'({mem[ad], 4'(i)}));
            addr_q.push_back(ad);
        end
        start_addr = a;
        count      = 5'(n);
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, " done seen"}, 32'(done_cnt != 0), 1);
        tick();
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " mem_read"}, mem_read, 0);
        check({tag, " data_valid"}, data_valid, 0);
        check({tag, " done"}, done, 0);
        check({tag, " mem_read_addr"}, mem_read_addr, 0);
        check({tag, " data"}, data, 0);
        check({tag, " data_index"}, data_index, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 12'h000;
        count      = 5'd0;
        ack_force  = 1'b0;
        ack_delay  = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h56;
        mem[12'h203] = 8'h78;
        mem[12'hFFE] = 8'hA1;
        mem[12'hFFF] = 8'hB2;
        mem[12'h000] = 8'hC3;

        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic 4-byte read with cycle-exact timing.
        xfer(12'h200, 4);
        check("t1 busy at N+1", busy, 1);
        check("t1 mem_read at N+1", mem_read, 1);
        wait_done("t1", 50);
        check("t1 first mem_read rel", mr_first_rel, 1);
        check("t1 dv count", dv_cnt, 4);
        for (int i = 0; i < dv_rel.size(); i++) check("t1 dv rel", dv_rel[i], 3 + 2 * i);
        check("t1 done rel", done_rel, 10);
        check("t1 done count", done_cnt, 1);
        check("t1 last data", data, 8'h78);
        check("t1 scoreboard drained", exp_q.size(), 0);

        // Zero-length transfer.
        xfer(12'h250, 0);
        check("t2 done at N+1", done, 1);
        check("t2 busy", busy, 0);
        wait_done("t2", 10);
        check("t2 no mem_read", mr_cnt, 0);
        check("t2 no data_valid", dv_cnt, 0);
        check("t2 done rel", done_rel, 1);
        check("t2 done count", done_cnt, 1);

        // Address wrap at the top of memory.
        xfer(12'hFFE, 3);
        wait_done("t3", 50);
        check("t3 dv count", dv_cnt, 3);
        check("t3 addresses drained", addr_q.size(), 0);
        check("t3 scoreboard drained", exp_q.size(), 0);

        // Second start mid-transfer is ignored.
        xfer(12'h200, 4);
        tick();
        start_addr = 12'h300;
        count      = 5'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4", 50);
        check("t4 dv count", dv_cnt, 4);
        check("t4 done count", done_cnt, 1);
        check("t4 done rel", done_rel, 10);
        check("t4 scoreboard drained", exp_q.size(), 0);

        // Reset right after the second byte of an 8-byte read.
        xfer(12'h210, 8);
        repeat (4) tick();
        check("t5 second dv present", data_valid, 1);
        check("t5 second dv index", data_index, 1);
        rst = 1'b1;
        tick();
        check_idle_outputs("t5 after rst");
        check("t5 dv count at reset", dv_cnt, 2);
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (6) tick();
        check("t5 no extra dv", dv_cnt, 2);
        check("t5 no done", done_cnt, 0);
        check("t5 busy idle", busy, 0);
        xfer(12'h200, 4);
        wait_done("t5 restart", 50);
        check("t5 restart dv count", dv_cnt, 4);
        check("t5 restart done rel", done_rel, 10);

        // Oversized count clamps to MAX_LEN.
        xfer(12'h400, 20);
        wait_done("t6", 100);
        check("t6 dv count", dv_cnt, 16);
        check("t6 last index", data_index, 15);
        check("t6 done rel", done_rel, 34);
        check("t6 scoreboard drained", exp_q.size(), 0);

        // Stray ack while idle, then a slow memory.
        arm();
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        tick();
        check("t7 stray ack dv", dv_cnt, 0);
        check("t7 stray ack busy", busy, 0);
        ack_delay = 3;
        xfer(12'h500, 2);
        wait_done("t7", 60);
        check("t7 dv count", dv_cnt, 2);
        check("t7 done rel", done_rel, 12);
        check("t7 scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory address width (4 KiB space).
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum bytes per transfer (covers Fx65 V0..VF and Dxyn sprite rows).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  12  first byte address.
REQ-007 SHALL have port count  input  5  bytes to read, 0..MAX_LEN.
REQ-008 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-009 SHALL have port mem_read  output  1  read strobe to memory.
REQ-010 SHALL have port mem_read_addr  output  12  read address to memory.
REQ-011 SHALL have port mem_read_data  input  8  byte returned by memory.
REQ-012 SHALL have port mem_read_ack  input  1  memory read acknowledge; data valid while high.
REQ-013 SHALL have port data_valid  output  1  one-cycle strobe per delivered byte.
REQ-014 SHALL have port data  output  8  delivered byte, stable while data_valid is high.
REQ-015 SHALL have port data_index  output  4  offset of delivered byte from start_addr.
REQ-016 SHALL have port done  output  1  one-cycle pulse at transfer end.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, FINISH; all outputs registered.
REQ-018 IDLE: start=1 with count>=1 SHALL latch start_addr and count, clear index, go to REQ, busy=1 next cycle.
REQ-019 IDLE: start=1 with count=0 SHALL go to FINISH with no memory read.
REQ-020 IDLE: count>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-021 REQ: SHALL drive mem_read=1 for exactly one cycle with mem_read_addr=base+index, then go to WAIT.
REQ-022 WAIT: mem_read SHALL be 0; on mem_read_ack=1, SHALL register data=mem_read_data, data_index=index, data_valid=1 in the next cycle.
REQ-023 WAIT with ack: if bytes remain, SHALL increment index and go to REQ; else go to FINISH.
REQ-024 Next mem_read SHALL coincide with the previous byte's data_valid cycle, giving 2 cycles/byte steady state.
REQ-025 Latency: start at edge N -> mem_read high cycle N+1, ack N+2, first data_valid N+3.
REQ-026 FINISH: SHALL pulse done=1 and busy=0 for one cycle, then return to IDLE; done for count=0 SHALL occur in cycle N+1.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (0xFFF+1 -> 0x000).
REQ-028 start while busy SHALL be ignored; latched start_addr/count SHALL not change mid-transfer.
REQ-029 mem_read_ack outside WAIT SHALL be ignored.
REQ-030 No timeout: WAIT SHALL hold indefinitely until ack.
REQ-031 data_valid SHALL be high for exactly count cycles per transfer; data/data_index SHALL hold last value otherwise.

Reset
REQ-032 rst=1 SHALL force IDLE and busy, mem_read, data_valid, done=0; mem_read_addr, data, data_index=0, at the next edge.
REQ-033 rst mid-transfer SHALL abort with no done pulse; a late ack after reset SHALL be ignored.

Structure
REQ-034 ADDR_WIDTH, MAX_LEN and the FSM state encoding SHALL live in shared package chip8_pkg.
REQ-035 SHALL be a single module with no sub-modules; verification bench SHALL instantiate it with memory.

Verification
REQ-036 Preload mem[0x200..0x203]=12 34 56 78, start addr 0x200 count 4 -> data 12,34,56,78 idx 0..3, data_valid cycles N+3,+5,+7,+9, done N+10.
REQ-037 count=0 -> no mem_read, done at N+1, no data_valid.
REQ-038 addr 0xFFE count 3 -> mem_read_addr 0xFFE,0xFFF,0x000, idx 0,1,2.
REQ-039 start pulsed again during transfer with addr 0x300 -> ignored, original bytes only, single done.
REQ-040 rst asserted after second data_valid of count 8 -> all outputs 0 next cycle, no done, new start then reads correctly.
REQ-041 count=20 -> clamped, exactly 16 data_valid, idx 0..15.
